// File: rtl/cook_timer_if.sv
// Keypad/enable inputs and status/display outputs of the cook timer.
interface cook_timer_if;
  logic       digit_valid;
  logic [3:0] digit;
  logic       clear;
  logic       enabler;
  logic       timer_done;
  logic       running;
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;

  modport master (
    output digit_valid, digit, clear, enabler,
    input  timer_done, running, min_tens, min_ones, sec_tens, sec_ones
  );

  modport slave (
    input  digit_valid, digit, clear, enabler,
    output timer_done, running, min_tens, min_ones, sec_tens, sec_ones
  );
endinterface

// File: rtl/cook_timer.sv
// MM:SS BCD cook timer: keypad entry, per-second countdown while enabled, done flag.
// All outputs registered, one-edge latency; no backpressure (strobes are taken or dropped).
module cook_timer #(
  parameter int TICKS_PER_SEC = 50_000_000
) (
  input logic         clk,
  input logic         reset,
  cook_timer_if.slave tmr
);
  localparam int            PW       = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0] PSC_MAX  = PW'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  typedef struct packed {
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
  } bcd_time_t;

  state_t          state, state_nxt;
  bcd_time_t       tm, tm_nxt, tm_dec;
  logic [PW-1:0]   psc, psc_nxt;
  logic            digit_ok;
  logic            time_zero;
  logic            counting;

  // One-second BCD decrement; sec_tens may hold 6-9 from entry, so it only borrows at 0.
  always_comb begin
    tm_dec = tm;
    if (tm.sec_ones != 4'd0) begin
      tm_dec.sec_ones = tm.sec_ones - 4'd1;
    end else begin
      tm_dec.sec_ones = 4'd9;
      if (tm.sec_tens != 4'd0) begin
        tm_dec.sec_tens = tm.sec_tens - 4'd1;
      end else begin
        tm_dec.sec_tens = 4'd5;
        if (tm.min_ones != 4'd0) begin
          tm_dec.min_ones = tm.min_ones - 4'd1;
        end else begin
          tm_dec.min_ones = 4'd9;
          tm_dec.min_tens = tm.min_tens - 4'd1;
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    tm_nxt    = tm;
    psc_nxt   = psc;
    digit_ok  = tmr.digit_valid && (tmr.digit <= 4'd9) && !tmr.enabler;
    time_zero = (tm == '0);
    // The IDLE->RUN edge already counts as a prescaler tick, so a paused partial second resumes exactly.
    counting  = tmr.enabler && ((state == RUN) || ((state == IDLE) && !time_zero));

    if (tmr.clear) begin
      state_nxt = IDLE;
      tm_nxt    = '0;
      psc_nxt   = '0;
    end else if (counting) begin
      state_nxt = RUN;
      if (psc == PSC_MAX) begin
        psc_nxt = '0;
        tm_nxt  = tm_dec;
        if (tm_dec == '0) state_nxt = DONE;
      end else begin
        psc_nxt = psc + PW'(1);
      end
    end else begin
      case (state)
        IDLE: begin
          if (tmr.enabler) begin
            state_nxt = DONE;
          end else if (digit_ok) begin
            tm_nxt.min_tens = tm.min_ones;
            tm_nxt.min_ones = tm.sec_tens;
            tm_nxt.sec_tens = tm.sec_ones;
            tm_nxt.sec_ones = tmr.digit;
            psc_nxt         = '0;
          end
        end
        RUN: state_nxt = IDLE;
        DONE: begin
          if (digit_ok) begin
            state_nxt = IDLE;
            tm_nxt    = {12'h000, tmr.digit};
            psc_nxt   = '0;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      tm    <= '0;
      psc   <= '0;
    end else begin
      state <= state_nxt;
      tm    <= tm_nxt;
      psc   <= psc_nxt;
    end
  end

  assign tmr.timer_done = (state == DONE);
  assign tmr.running    = (state == RUN);
  assign tmr.min_tens   = tm.min_tens;
  assign tmr.min_ones   = tm.min_ones;
  assign tmr.sec_tens   = tm.sec_tens;
  assign tmr.sec_ones   = tm.sec_ones;
endmodule
